// File: rtl/h_matrix_buffer.sv
// h_matrix_buffer: circular buffer of complex channel matrices feeding a QR core.
// Each entry stores a matrix together with a reuse count. The head entry is
// presented (reuse + 1) times before it is popped. out_last marks the final
// presentation of the head entry.
// Optional feature: define HBUF_DROP_CNT_EN to add the drop_cnt output. It counts
// the cycles in which a matrix was offered while the buffer was full.
module h_matrix_buffer #(
    parameter int DATA_W  = 32,
    parameter int N_ANT   = 2,
    parameter int DEPTH   = 4,
    parameter int REUSE_W = 4,
    localparam int MAT_W  = 2 * N_ANT * N_ANT * DATA_W,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAT_W-1:0]   h_in,
    input  logic [REUSE_W-1:0] reuse,
    output logic               out_valid,
    input  logic               out_accept,
    output logic [MAT_W-1:0]   h_out,
    output logic               out_last,
    output logic [CNT_W-1:0]   count
`ifdef HBUF_DROP_CNT_EN
    ,
    output logic [15:0]        drop_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [REUSE_W-1:0] reuse;
        logic [MAT_W-1:0]   h;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    entry_t             mem [DEPTH];
    entry_t             head;
    state_t             state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [REUSE_W-1:0] rep_cnt;
    logic               push;
    logic               xfer;
    logic               pop;

    // Head entry and handshake outputs, all derived from registered state.
    assign head      = mem[rd_ptr];
    assign h_out     = head.h;
    assign out_valid = (state != EMPTY);
    assign out_last  = (state == EMPTY) || (rep_cnt == head.reuse);
    assign in_ready  = (state != FULL) && !reset;

    // Qualify push, presentation transfer and pop for this cycle.
    // NOTE: always_comb assigns every output on every path, so no latch is inferred.
    always_comb begin
        push = enable && in_valid && in_ready && !flush;
        xfer = enable && out_valid && out_accept && !flush;
        pop  = xfer && out_last;
    end

    // Matrix storage: written on push only, never reset.
    // NOTE: storage carries no reset; only the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{reuse: reuse, h: h_in};
        end
    end

    // Occupancy FSM with pointers, count and per-entry presentation counter.
    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= EMPTY;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rep_cnt <= '0;
        end else if (enable) begin
            if (flush) begin
                state   <= EMPTY;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                rep_cnt <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                end
                if (xfer) begin
                    rep_cnt <= out_last ? '0 : rep_cnt + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
                case (state)
                    EMPTY: begin
                        if (push) begin
                            state <= PARTIAL;
                        end
                    end
                    PARTIAL: begin
                        if (push && !pop && (count == CNT_W'(DEPTH - 1))) begin
                            state <= FULL;
                        end else if (pop && !push && (count == CNT_W'(1))) begin
                            state <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            state <= PARTIAL;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

`ifdef HBUF_DROP_CNT_EN
    // Saturating count of cycles in which an offered matrix could not be taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (enable) begin
            if (flush) begin
                drop_cnt <= '0;
            end else if (in_valid && !in_ready && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_h_matrix_buffer.sv
// tb_h_matrix_buffer: directed stimulus with a scoreboard queue of expected
// presentations. A negedge monitor pops and compares on every transfer.
module tb_h_matrix_buffer;

    localparam int DATA_W  = 32;
    localparam int N_ANT   = 2;
    localparam int DEPTH   = 4;
    localparam int REUSE_W = 4;
    localparam int MAT_W   = 2 * N_ANT * N_ANT * DATA_W;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [MAT_W-1:0]   h_in;
    logic [REUSE_W-1:0] reuse;
    logic               out_valid;
    logic               out_accept;
    logic [MAT_W-1:0]   h_out;
    logic               out_last;
    logic [CNT_W-1:0]   count;
`ifdef HBUF_DROP_CNT_EN
    logic [15:0]        drop_cnt;
`endif

    typedef struct {
        logic [MAT_W-1:0] h;
        logic             last;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    h_matrix_buffer #(
        .DATA_W (DATA_W),
        .N_ANT  (N_ANT),
        .DEPTH  (DEPTH),
        .REUSE_W(REUSE_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .h_in      (h_in),
        .reuse     (reuse),
        .out_valid (out_valid),
        .out_accept(out_accept),
        .h_out     (h_out),
        .out_last  (out_last),
        .count     (count)
`ifdef HBUF_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [MAT_W-1:0] mk(input int k);
        logic [31:0] w;
        w = 32'hA5000000 | 32'(k);
        return {(MAT_W / 32){w}};
    endfunction

    // Queue reuse+1 presentations of one matrix; only the final one is last.
    task automatic push_exp(input logic [MAT_W-1:0] h, input int r);
        for (int i = 0; i <= r; i++) begin
            sb.push_back('{h: h, last: (i == r)});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int k, input int r);
        in_valid = 1'b1;
        h_in     = mk(k);
        reuse    = REUSE_W'(r);
        push_exp(mk(k), r);
        step();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (count != 0 && n < 100) begin
            step();
            n++;
        end
        check({name, "_count0"}, count, 0);
        check({name, "_valid0"}, out_valid, 0);
        check({name, "_sb_empty"}, sb.size(), 0);
    endtask

    // Monitor: every transfer must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (enable && out_valid && out_accept && !flush && !reset) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_output: got h_out=%0h, expected no transfer", h_out);
                end else begin
                    e = sb.pop_front();
                    check("h_out", h_out, e.h);
                    check("out_last", out_last, e.last);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        h_in       = '0;
        reuse      = '0;
        out_accept = 1'b0;

        // Reset state.
        repeat (2) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 1);
        check("rst_count", count, 0);
        check("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Three single-presentation matrices streamed back to back.
        out_accept = 1'b1;
        offer(1, 0);
        check("latency_out_valid", out_valid, 1);
        offer(2, 0);
        offer(3, 0);
        in_valid = 1'b0;
        drain("abc");

        // Reuse of 2 gives three presentations.
        offer(16, 2);
        in_valid = 1'b0;
        drain("reuse2");

        // Maximum reuse gives 2^REUSE_W presentations.
        offer(32, (1 << REUSE_W) - 1);
        in_valid = 1'b0;
        drain("reuse_max");

        // Fill, hold input against a full buffer, then wrap the write pointer.
        out_accept = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offer(48 + i, 0);
        end
        in_valid = 1'b1;
        h_in     = mk(52);
        reuse    = '0;
        check("full_count", count, DEPTH);
        check("full_in_ready", in_ready, 0);
        repeat (5) step();
        in_valid = 1'b0;
`ifdef HBUF_DROP_CNT_EN
        check("drop_cnt5", drop_cnt, 5);
`endif
        out_accept = 1'b1;
        step();
        out_accept = 1'b0;
        offer(52, 0);
        in_valid = 1'b0;
        check("refill_count", count, DEPTH);
        out_accept = 1'b1;
        drain("wrap");

        // Simultaneous push and pop at count 2.
        out_accept = 1'b0;
        offer(64, 0);
        offer(65, 0);
        out_accept = 1'b1;
        for (int i = 0; i < 6; i++) begin
            offer(66 + i, 0);
            check("pushpop_count", count, 2);
        end
        in_valid = 1'b0;
        drain("pushpop");

        // Flush with a matrix offered in the same cycle.
        out_accept = 1'b0;
        offer(80, 0);
        offer(81, 0);
        offer(82, 0);
        check("preflush_count", count, 3);
        flush    = 1'b1;
        in_valid = 1'b1;
        h_in     = mk(83);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check("flush_count", count, 0);
        check("flush_out_valid", out_valid, 0);
`ifdef HBUF_DROP_CNT_EN
        check("flush_drop_cnt", drop_cnt, 0);
`endif
        out_accept = 1'b1;
        offer(84, 0);
        in_valid = 1'b0;
        drain("postflush");

        // enable=0 freezes state and ignores flush.
        out_accept = 1'b0;
        offer(96, 0);
        enable     = 1'b0;
        flush      = 1'b1;
        in_valid   = 1'b1;
        h_in       = mk(97);
        out_accept = 1'b1;
        repeat (2) step();
        check("frozen_count", count, 1);
        check("frozen_out_valid", out_valid, 1);
        check("frozen_h_out", h_out, mk(96));
        enable   = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        drain("unfreeze");

        // Reset in the middle of a reuse sequence.
        out_accept = 1'b1;
        in_valid   = 1'b1;
        h_in       = mk(112);
        reuse      = REUSE_W'(3);
        sb.push_back('{h: mk(112), last: 1'b0});
        step();
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreuse_rst_count", count, 0);
        check("midreuse_rst_out_last", out_last, 1);
        check("midreuse_rst_out_valid", out_valid, 0);
        check("midreuse_sb_consumed", sb.size(), 0);
        offer(113, 1);
        in_valid = 1'b0;
        drain("after_rst");

        check("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/h_matrix_buffer.md
H_MATRIX_BUFFER -- requirements
Module: h_matrix_buffer

Interface
REQ-001 Parameter DATA_W, 32, width of one real or imaginary component.
REQ-002 Parameter N_ANT, 2, antenna count; matrix is N_ANT x N_ANT complex.
REQ-003 Parameter DEPTH, 4, matrix entries held, DEPTH >= 2, power of two not required.
REQ-004 Parameter REUSE_W, 4, width of per-matrix reuse count.
REQ-005 Derived MAT_W = 2*N_ANT*N_ANT*DATA_W, CNT_W = clog2(DEPTH+1).
REQ-006 clk  input  1  sole clock, all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  0 freezes all state, and no push or pop occurs.
REQ-009 flush  input  1  discards all entries.
REQ-010 in_valid  input  1  h_in and reuse valid.
REQ-011 in_ready  output  1  buffer can take a matrix.
REQ-012 h_in  input  MAT_W  channel matrix, entry packing passed through unchanged.
REQ-013 reuse  input  REUSE_W  extra presentations of this matrix, stored with the entry.
REQ-014 out_valid  output  1  h_out holds a buffered matrix.
REQ-015 out_accept  input  1  downstream QR core accepts h_out this cycle.
REQ-016 h_out  output  MAT_W  head-entry matrix.
REQ-017 out_last  output  1  current presentation is the final one for the head entry.
REQ-018 count  output  CNT_W  entries held.

Function
REQ-019 Storage SHALL be a circular buffer with wr_ptr/rd_ptr wrapping from DEPTH-1 to 0.
REQ-020 Push SHALL occur when enable && in_valid && in_ready && !flush; mem[wr_ptr] <= {reuse, h_in}.
REQ-021 in_ready SHALL be (count < DEPTH) && !reset, with no push into a full buffer even when a pop occurs in the same cycle.
REQ-022 A transfer SHALL occur when enable && out_valid && out_accept && !flush.
REQ-023 rep_cnt (REUSE_W bits) SHALL increment on each transfer with out_last=0, and SHALL clear to 0 on a transfer with out_last=1.
REQ-024 out_last SHALL be (rep_cnt == stored reuse of head); a transfer with out_last=1 pops the head.
REQ-025 out_valid SHALL be (count != 0), and h_out SHALL be the head matrix, driven from registered state only.
REQ-026 Latency: a matrix pushed into an empty buffer at edge N SHALL appear with out_valid=1 in the cycle after edge N.
REQ-027 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-028 States SHALL be EMPTY (count=0), PARTIAL and FULL (count=DEPTH), with transitions by push/pop only: EMPTY->PARTIAL on push, PARTIAL->FULL on push reaching DEPTH, FULL->PARTIAL on pop, PARTIAL->EMPTY on last pop.
REQ-029 With DEPTH=1 excluded, EMPTY->FULL in one cycle SHALL NOT occur.
REQ-030 When flush=1 with enable=1, the block SHALL clear pointers, count and rep_cnt at the edge, and SHALL discard any push in the same cycle.
REQ-031 When enable=0, flush SHALL be ignored and outputs SHALL hold their values.
REQ-032 reuse=0 SHALL give a single presentation, and reuse=2^REUSE_W-1 SHALL give 2^REUSE_W presentations.

Reset
REQ-033 With reset=1 at an edge: pointers, count, rep_cnt = 0, and reset SHALL override enable and flush.
REQ-034 Reset outputs SHALL be out_valid=0, out_last=1, count=0, in_ready=0 during reset and 1 on the first cycle after it; mem contents SHALL NOT be reset.
REQ-035 Reset mid-reuse SHALL abandon the head entry and all queued entries.

Configuration
REQ-036 Macro HBUF_DROP_CNT_EN: when defined, output drop_cnt [15:0] SHALL count cycles with enable && in_valid && !in_ready && !reset, SHALL saturate at 16'hFFFF, and SHALL be cleared by reset and flush.
REQ-037 Without HBUF_DROP_CNT_EN, the drop_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-038 Push A,B,C (reuse=0) with out_accept=1 -> A,B,C out in order, one per cycle, out_last=1 each, and count returns to 0.
REQ-039 Push A with reuse=2, out_accept=1 -> A presented 3 transfers, out_last=0,0,1, then out_valid=0.
REQ-040 Fill 4 entries, out_accept=0 -> count=4, in_ready=0; then in_valid=1 for 5 cycles -> drop_cnt=5 (macro on), and after wrap the 5th push is accepted and read back in order.
REQ-041 count=2, simultaneous push and pop for 6 cycles -> count stays 2, pointers wrap, and order is preserved.
REQ-042 flush with in_valid=1 and count=3 -> next cycle count=0, out_valid=0, and the flushed-cycle matrix is absent.
REQ-043 reset mid-reuse (rep_cnt=1) -> count=0, out_last=1, and the next pushed matrix starts at rep_cnt=0.
